img_pos_sched: RTL and testbench

Frame-synchronised position scheduler for the 120×120 sprite drawn by the TFT image sender. It counts displayed frames from the timing generator's `hcnt`/`vcnt`/`tft_de`. It advances the sprite origin (`img_hbegin`, `img_vbegin`) either through a fixed six-tile tour or by bouncing it across the panel. Origins change only in vertical blanking, so the sender never shows a torn sprite. It sits between the TFT timing generator and the image sender, replacing free-running time-based relocation.

---
 rtl/img_pkg.sv | 34 +++
 rtl/tft_frame_tick.sv | 26 ++
 rtl/img_pos_sched.sv | 111 +++++++++++
 tb/tb_img_pos_sched.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// img_pkg: shared geometry, state encoding, tile table and bounce step for the sprite scheduler
package img_pkg;
  localparam int IMG_H = 120;
  localparam int IMG_V = 120;
  localparam int TFT_H = 480;
  localparam int TFT_V = 272;
  localparam int STEP_PX = 4;
  localparam int MAX_H = TFT_H - IMG_H;
  localparam int MAX_V = TFT_V - IMG_V;
  typedef enum logic [1:0] {IDLE, WAIT, CALC, COMMIT} state_t;
  typedef struct packed {
    logic [9:0] pos;
    logic       neg;
  } axis_t;
  localparam logic [9:0] TILE_H [6] = '{10'd0, 10'(IMG_H), 10'(2*IMG_H), 10'(2*IMG_H), 10'(IMG_H), 10'd0};
  localparam logic [9:0] TILE_V [6] = '{10'd0, 10'd0, 10'd0, 10'(IMG_V), 10'(IMG_V), 10'(IMG_V)};
  function automatic axis_t bounce(input logic [9:0] cur, input logic neg, input logic [9:0] lim);
    logic signed [10:0] s;
    logic signed [10:0] n;
    axis_t r;
    s = 11'(STEP_PX);
    n = $signed({1'b0, cur}) + (neg ? -s : s);
    r.pos = n[9:0];
    r.neg = neg;
    if (n > $signed({1'b0, lim})) begin
      r.pos = lim;
      r.neg = 1'b1;
    end else if (n < 0) begin
      r.pos = 10'd0;
      r.neg = 1'b0;
    end
    return r;
  endfunction
endpackage

// File: rtl/tft_frame_tick.sv
// tft_frame_tick: registered one-cycle tick when active video ends after the last active line
module tft_frame_tick #(
  parameter int LAST_LINE = 271
) (
  input  logic       clk50M,
  input  logic       rst_n,
  input  logic       tft_de,
  input  logic [9:0] vcnt,
  output logic       tick
);
  logic       de_q;
  logic [9:0] vcnt_q;
  logic       tick_q;
  always_ff @(posedge clk50M) begin
    if (!rst_n) begin
      de_q   <= 1'b0;
      vcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      de_q   <= tft_de;
      vcnt_q <= vcnt;
      tick_q <= !tft_de && de_q && vcnt_q == 10'(LAST_LINE);
    end
  end
  assign tick = tick_q;
endmodule

// File: rtl/img_pos_sched.sv
// img_pos_sched: frame-synchronised sprite origin scheduler (tile tour or bounce)
module img_pos_sched
  import img_pkg::*;
(
  input  logic       clk50M,
  input  logic       rst_n,
  input  logic       tft_de,
  input  logic [9:0] hcnt,
  input  logic [9:0] vcnt,
  input  logic       run,
  input  logic       step_req,
  input  logic       mode,
  input  logic [7:0] frame_div,
  output logic [9:0] img_hbegin,
  output logic [9:0] img_vbegin,
  output logic       pos_update,
  output logic       busy
);
  state_t     state_q;
  logic [7:0] cnt_q;
  logic [2:0] idx_q;
  logic       dh_q, dv_q, pend_q, lmode_q, upd_q, busy_q;
  logic [9:0] h_q, v_q;
  logic       tick, chg, unused_hcnt;
  logic [7:0] div_eff;
  logic [8:0] cnt_n;
  logic [2:0] idx_n;
  logic [9:0] nh, nv;
  axis_t      bh, bv;
  assign unused_hcnt = ^hcnt;
  tft_frame_tick #(.LAST_LINE(TFT_V - 1)) u_tick (
    .clk50M(clk50M),
    .rst_n (rst_n),
    .tft_de(tft_de),
    .vcnt  (vcnt),
    .tick  (tick)
  );
  // a mode switch restarts tile at index 0 and bounce with directions (+,+)
  always_comb begin
    div_eff = frame_div == 8'd0 ? 8'd1 : frame_div;
    cnt_n   = {1'b0, cnt_q} + 9'd1;
    chg     = mode != lmode_q;
    idx_n   = chg || idx_q == 3'd5 ? 3'd0 : idx_q + 3'd1;
    bh      = bounce(h_q, chg ? 1'b0 : dh_q, 10'(MAX_H));
    bv      = bounce(v_q, chg ? 1'b0 : dv_q, 10'(MAX_V));
    nh      = mode ? bh.pos : TILE_H[idx_n];
    nv      = mode ? bv.pos : TILE_V[idx_n];
  end
  // outputs load on leaving CALC so the new origin and pulse are visible during COMMIT
  always_ff @(posedge clk50M) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      dh_q    <= 1'b0;
      dv_q    <= 1'b0;
      pend_q  <= 1'b0;
      lmode_q <= 1'b0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      upd_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (run) state_q <= WAIT;
          else begin
            if (step_req) pend_q <= 1'b1;
            if (tick && pend_q) begin
              state_q <= CALC;
              busy_q  <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (!run) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (tick) begin
            if (cnt_n >= {1'b0, div_eff}) begin
              cnt_q   <= '0;
              state_q <= CALC;
              busy_q  <= 1'b1;
            end else cnt_q <= cnt_n[7:0];
          end
        end
        CALC: begin
          h_q     <= nh;
          v_q     <= nv;
          upd_q   <= 1'b1;
          lmode_q <= mode;
          if (mode) begin
            dh_q <= bh.neg;
            dv_q <= bv.neg;
          end else idx_q <= idx_n;
          state_q <= COMMIT;
        end
        default: begin
          pend_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= run ? WAIT : IDLE;
        end
      endcase
    end
  end
  assign img_hbegin = h_q;
  assign img_vbegin = v_q;
  assign pos_update = upd_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_img_pos_sched.sv
// tb_img_pos_sched: table, hand-written and randomized frame checks against a frame-level model
module tb_img_pos_sched;
  logic       clk50M = 1'b0;
  logic       rst_n = 1'b0;
  logic       tft_de = 1'b0;
  logic [9:0] hcnt = '0;
  logic [9:0] vcnt = '0;
  logic       run = 1'b0;
  logic       step_req = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] frame_div = 8'd1;
  logic [9:0] img_hbegin, img_vbegin;
  logic       pos_update, busy;

  img_pos_sched dut (
    .clk50M    (clk50M),
    .rst_n     (rst_n),
    .tft_de    (tft_de),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .run       (run),
    .step_req  (step_req),
    .mode      (mode),
    .frame_div (frame_div),
    .img_hbegin(img_hbegin),
    .img_vbegin(img_vbegin),
    .pos_update(pos_update),
    .busy      (busy)
  );

  always #10 clk50M = ~clk50M;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // origin may only move while video is blanked
  logic [19:0] mon_prev = '0;
  always @(posedge clk50M) begin
    #1;
    if ({img_hbegin, img_vbegin} !== mon_prev) begin
      chk("origin_change_de", {31'd0, tft_de}, 32'd0);
      mon_prev = {img_hbegin, img_vbegin};
    end
  end

  // frame-level reference model
  int m_h, m_v, m_idx, m_cnt, m_div;
  bit m_dh, m_dv, m_lmode, m_mode, m_run, m_pend;
  int tile_h[6] = '{0, 120, 240, 240, 120, 0};
  int tile_v[6] = '{0, 0, 0, 120, 120, 120};

  function automatic void mdl_reset();
    m_h = 0; m_v = 0; m_idx = 0; m_cnt = 0; m_dh = 0; m_dv = 0;
    m_lmode = 0; m_pend = 0;
  endfunction

  function automatic void axis(inout int p, inout bit d, input int lim);
    int n = p + (d ? -4 : 4);
    if (n > lim) begin p = lim; d = 1; end
    else if (n < 0) begin p = 0; d = 0; end
    else p = n;
  endfunction

  function automatic void mdl_frame(output bit upd);
    upd = 0;
    if (m_run) begin
      m_cnt++;
      if (m_cnt >= (m_div == 0 ? 1 : m_div)) begin m_cnt = 0; upd = 1; end
    end else if (m_pend) upd = 1;
    if (!upd) return;
    m_pend = 0;
    if (m_mode != m_lmode) begin
      m_lmode = m_mode;
      m_dh = 0; m_dv = 0;
      if (!m_mode) begin m_idx = 0; m_h = 0; m_v = 0; return; end
    end else if (!m_mode) m_idx = (m_idx + 1) % 6;
    if (m_mode) begin
      axis(m_h, m_dh, 360);
      axis(m_v, m_dv, 152);
    end else begin
      m_h = tile_h[m_idx]; m_v = tile_v[m_idx];
    end
  endfunction

  task automatic do_reset();
    @(negedge clk50M);
    rst_n = 0; run = 0; step_req = 0; mode = 0; frame_div = 8'd1; tft_de = 0;
    repeat (2) @(negedge clk50M);
    rst_n = 1;
    mdl_reset();
    m_run = 0; m_mode = 0; m_div = 1;
  endtask

  task automatic set_ctrl(input bit r, input bit m, input logic [7:0] d, input bit s);
    if (r != m_run) m_cnt = 0;
    if (s && !m_run && !r) m_pend = 1;
    m_run = r; m_mode = m; m_div = int'(d);
    @(negedge clk50M);
    run = r; mode = m; frame_div = d; step_req = s;
    @(negedge clk50M);
    step_req = 0;
  endtask

  // lines 0, 270 and 271 only; just the fall after 271 may tick
  task automatic frame(input bit eu, input logic [9:0] eh, input logic [9:0] ev, input bit rc,
                       output logic [9:0] oh, output logic [9:0] ov);
    logic [9:0] lines [3];
    lines = '{10'd0, 10'd270, 10'd271};
    oh = '0; ov = '0;
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk50M);
        tft_de = 1; vcnt = lines[l]; hcnt = 10'(i);
      end
      @(negedge clk50M);
      tft_de = 0;
      @(negedge clk50M);
      if (l == 2) begin
        chk("upd_early", {31'd0, pos_update}, 32'd0);
        @(negedge clk50M);
        chk("busy_calc", {31'd0, busy}, {31'd0, eu});
        if (rc) rst_n = 0;
        @(negedge clk50M);
        rst_n = 1;
        chk("pos_update", {31'd0, pos_update}, {31'd0, eu && !rc});
        chk("hbegin", {22'd0, img_hbegin}, {22'd0, eh});
        chk("vbegin", {22'd0, img_vbegin}, {22'd0, ev});
        oh = img_hbegin; ov = img_vbegin;
        @(negedge clk50M);
        chk("upd_len", {31'd0, pos_update}, 32'd0);
        chk("busy_done", {31'd0, busy}, 32'd0);
        vcnt = 10'd272;
        repeat (3) @(negedge clk50M);
      end
    end
  endtask

  task automatic mframe(output bit u, output logic [9:0] oh, output logic [9:0] ov);
    mdl_frame(u);
    frame(u, 10'(m_h), 10'(m_v), 0, oh, ov);
  endtask

  typedef struct {
    bit         run, mode, step, upd;
    logic [7:0] div;
    logic [9:0] h, v;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt [19];
    bit u;
    logic [9:0] oh, ov;
    int nupd, first_at, second_at;
    vt = '{
      '{0, 0, 0, 0, 8'd1, 10'd0,   10'd0},
      '{0, 0, 0, 0, 8'd1, 10'd0,   10'd0},
      '{1, 0, 0, 1, 8'd1, 10'd120, 10'd0},
      '{1, 0, 0, 1, 8'd1, 10'd240, 10'd0},
      '{1, 0, 0, 1, 8'd1, 10'd240, 10'd120},
      '{1, 0, 0, 1, 8'd1, 10'd120, 10'd120},
      '{1, 0, 0, 1, 8'd1, 10'd0,   10'd120},
      '{1, 0, 0, 1, 8'd1, 10'd0,   10'd0},
      '{1, 0, 0, 1, 8'd1, 10'd120, 10'd0},
      '{0, 0, 0, 0, 8'd1, 10'd120, 10'd0},
      '{0, 0, 1, 1, 8'd1, 10'd240, 10'd0},
      '{0, 0, 0, 0, 8'd1, 10'd240, 10'd0},
      '{1, 1, 0, 1, 8'd0, 10'd244, 10'd4},
      '{1, 1, 0, 1, 8'd1, 10'd248, 10'd8},
      '{1, 0, 0, 1, 8'd1, 10'd0,   10'd0},
      '{1, 0, 0, 1, 8'd1, 10'd120, 10'd0},
      '{1, 0, 0, 0, 8'd2, 10'd120, 10'd0},
      '{1, 0, 0, 1, 8'd2, 10'd240, 10'd0},
      '{0, 0, 0, 0, 8'd1, 10'd240, 10'd0}
    };
    do_reset();
    @(negedge clk50M);
    chk("rst_h", {22'd0, img_hbegin}, 32'd0);
    chk("rst_v", {22'd0, img_vbegin}, 32'd0);
    chk("rst_upd", {31'd0, pos_update}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    foreach (vt[i]) begin
      set_ctrl(vt[i].run, vt[i].mode, vt[i].div, vt[i].step);
      mdl_frame(u);
      frame(vt[i].upd, vt[i].h, vt[i].v, 0, oh, ov);
    end

    // run rising together with a step pulse: the step is dropped
    set_ctrl(1, 0, 8'd1, 1);
    set_ctrl(0, 0, 8'd1, 0);
    mdl_frame(u);
    frame(0, 10'd240, 10'd0, 0, oh, ov);

    // reset during CALC discards the pending commit
    set_ctrl(1, 0, 8'd1, 0);
    frame(1, 10'd0, 10'd0, 1, oh, ov);
    mdl_reset();
    mdl_frame(u);
    frame(1, 10'd120, 10'd0, 0, oh, ov);

    // frame division 0 then 30
    do_reset();
    set_ctrl(1, 0, 8'd0, 0);
    nupd = 0;
    for (int i = 0; i < 3; i++) begin mframe(u, oh, ov); nupd += int'(u); end
    chk("div0_updates", nupd, 3);
    set_ctrl(1, 0, 8'd30, 0);
    nupd = 0; first_at = 0; second_at = 0;
    for (int i = 1; i <= 60; i++) begin
      mframe(u, oh, ov);
      if (u) begin
        nupd++;
        if (nupd == 1) first_at = i; else second_at = i;
      end
    end
    chk("div30_updates", nupd, 2);
    chk("div30_first", first_at, 30);
    chk("div30_second", second_at, 60);

    // bounce from reset
    do_reset();
    set_ctrl(1, 1, 8'd1, 0);
    for (int i = 1; i <= 92; i++) begin
      mframe(u, oh, ov);
      if (i == 38) chk("y_at_38", {22'd0, ov}, 32'd152);
      if (i == 40) chk("y_at_40", {22'd0, ov}, 32'd148);
      if (i == 90) chk("x_at_90", {22'd0, oh}, 32'd360);
      if (i == 92) chk("x_at_92", {22'd0, oh}, 32'd356);
    end

    // bounce to tile switch from (52,52)
    do_reset();
    set_ctrl(1, 1, 8'd1, 0);
    for (int i = 0; i < 13; i++) mframe(u, oh, ov);
    chk("b13_x", {22'd0, oh}, 32'd52);
    chk("b13_y", {22'd0, ov}, 32'd52);
    set_ctrl(1, 0, 8'd1, 0);
    mdl_frame(u);
    frame(1, 10'd0, 10'd0, 0, oh, ov);

    // randomized control changes against the model
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(2) == 0)
        set_ctrl($urandom_range(3) != 0, ($urandom_range(3) == 0) ? !m_mode : m_mode,
                 8'($urandom_range(3)), $urandom_range(1) == 1);
      mframe(u, oh, ov);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
